load_queue: RTL and testbench
=============================

Name: load_queue

Overview:
Multi-entry, parametrised load buffer that replaces the single-entry load buffer between the address calculation unit (ACU) and data memory. It accepts resolved loads in program order into a circular queue. It issues them in order to MEM, one outstanding request at a time, and only when the ROB reports no pending older stores. It extracts and extends the returned data by access size, then broadcasts each result on the CDB under a grant handshake.

Parameters:
LQ_DEPTH, 4, number of entries (power of 2, ≥2)
XLEN, 32, address/data width
ROB_TAG_LEN, 5, ROB tag width

Ports:
clock  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
lq_in_valid  in  1  ACU presents a load
lq_in_address  in  XLEN  load byte address
lq_in_rob_tag  in  ROB_TAG_LEN  destination ROB tag
lq_in_size  in  2  0=byte, 1=half, 2=word
lq_in_unsigned  in  1  zero-extend when 1
full  out  1  no free entry, to ACU
count  out  $clog2(LQ_DEPTH+1)  occupied entries
pending_stores  in  1  ROB: older stores not yet committed
mem_busy  in  1  MEM cannot accept a request this cycle
mem_req  out  1  read request
mem_addr  out  XLEN  word-aligned address {addr[XLEN-1:2],2'b00}
mem_resp_valid  in  1  read data valid
mem_resp_data  in  XLEN  full word read data
cdb_valid  out  1  result ready
cdb_rob_tag  out  ROB_TAG_LEN  tag of result
cdb_value  out  XLEN  extended load value
cdb_grant  in  1  CDB accepts result this cycle
flush  in  1  squash all entries, e.g. on mispredict

Behaviour:
- Storage: circular array with head, issue and tail pointers, each $clog2(LQ_DEPTH) bits, wrapping mod LQ_DEPTH.
- Per-entry state: FREE -> WAIT (allocated) -> ISSUED (request accepted) -> DONE (data latched) -> FREE (CDB granted).
- Reset (reset=0, asynchronous): all entries FREE; pointers 0; outstanding=0; drop=0.
- Outputs while in reset: full=0, count=0, mem_req=0, mem_addr=0, cdb_valid=0, cdb_rob_tag=0, cdb_value=0.
- Allocation: on the rising edge with lq_in_valid && !full, the tail entry takes address, tag, size and unsigned, goes to WAIT, and tail increments. If lq_in_valid && full, the input is ignored; the ACU holds it.
- full is (count==LQ_DEPTH), combinational from registered state. A free in the same cycle does not unblock allocation until the next cycle.
- Issue: mem_req = entry[issue] in WAIT && !pending_stores && !outstanding. This is combinational from registered state.
- Issue latency: earliest mem_req is the cycle after allocation.
- On an edge with mem_req && !mem_busy: the entry goes to ISSUED, outstanding=1, issue increments. With mem_busy=1 the request holds and is retried.
- mem_addr is driven only while mem_req=1; otherwise 0.
- Response: mem_resp_valid with outstanding=1 and drop=0 latches data into the ISSUED entry, moves it to DONE, and clears outstanding. Any other mem_resp_valid is ignored.
- Data extraction: shift = addr[1:0]*8 for a byte, addr[1]*16 for a half, 0 for a word.
- Extension: byte and half values are sign-extended, or zero-extended when unsigned=1. Misaligned accesses are not checked.
- Writeback: cdb_valid = entry[head] in DONE. cdb_rob_tag and cdb_value come from the head entry. Completion is in order, so only the head can be DONE first.
- cdb_valid, tag and value stay stable until cdb_grant. On an edge with cdb_valid && cdb_grant, head is freed and increments.
- Earliest cdb_valid is the cycle after mem_resp_valid.
- count is updated as +alloc −free. Simultaneous allocation and free when not full leaves count unchanged.
- flush (synchronous, highest priority over all other events that edge):
  - All entries become FREE, pointers 0, count 0.
  - Same-cycle allocation, issue and free are discarded.
  - If outstanding=1 and no response arrives in the flush cycle, set drop=1. The next mem_resp_valid clears drop and outstanding, and its data is discarded.
  - While drop=1, mem_req=0.
- reset asserted mid-operation clears everything, including drop. Responses arriving after reset are ignored (outstanding=0).

Test Plan:
- Reset: hold reset=0 with random inputs -> all outputs 0. Release; one idle cycle -> still 0.
- Fill/full (LQ_DEPTH=4, pending_stores=1): 5 back-to-back loads with tags 1..5 -> after 4 edges full=1 and count=4; tag 5 not stored. cdb_grant with nothing DONE -> no change.
- Store ordering: entry addr 0x100 waiting, pending_stores=1 for 3 cycles -> mem_req=0. Drop pending_stores -> same cycle mem_req=1, mem_addr=0x100.
- Busy/extension: lb at 0x103, mem_busy=1 for 2 cycles -> request held. Response 0x80112233 -> cdb_value=0xFFFFFF80. lbu same address -> 0x00000080. lh at 0x102 -> 0xFFFF8011.
- CDB stall: result DONE, cdb_grant=0 for 4 cycles -> cdb_valid, tag and value constant, count constant. Grant -> count decrements next cycle; the next entry issues.
- Flush with outstanding: flush the cycle after issue -> count=0. Response one cycle later with 0xDEADBEEF -> no cdb_valid. A new load at 0x200 then issues and completes with its own data.

Source files
------------

// File: rtl/load_queue.sv
// In-order load queue between the ACU and data memory: circular buffer,
// single outstanding MEM read, size/sign extraction and CDB writeback.
module load_queue #(
    parameter int LQ_DEPTH    = 4,
    parameter int XLEN        = 32,
    parameter int ROB_TAG_LEN = 5
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         lq_in_valid,
    input  logic [XLEN-1:0]              lq_in_address,
    input  logic [ROB_TAG_LEN-1:0]       lq_in_rob_tag,
    input  logic [1:0]                   lq_in_size,
    input  logic                         lq_in_unsigned,
    output logic                         full,
    output logic [$clog2(LQ_DEPTH+1)-1:0] count,
    input  logic                         pending_stores,
    input  logic                         mem_busy,
    output logic                         mem_req,
    output logic [XLEN-1:0]              mem_addr,
    input  logic                         mem_resp_valid,
    input  logic [XLEN-1:0]              mem_resp_data,
    output logic                         cdb_valid,
    output logic [ROB_TAG_LEN-1:0]       cdb_rob_tag,
    output logic [XLEN-1:0]              cdb_value,
    input  logic                         cdb_grant,
    input  logic                         flush
);
    localparam int PW = $clog2(LQ_DEPTH);
    localparam int CW = $clog2(LQ_DEPTH+1);

    typedef enum logic [1:0] {E_FREE, E_WAIT, E_ISSUED, E_DONE} est_t;

    est_t                   st_q   [LQ_DEPTH];
    logic [XLEN-1:0]        addr_q [LQ_DEPTH];
    logic [XLEN-1:0]        data_q [LQ_DEPTH];
    logic [ROB_TAG_LEN-1:0] tag_q  [LQ_DEPTH];
    logic [1:0]             size_q [LQ_DEPTH];
    logic                   uns_q  [LQ_DEPTH];

    logic [PW-1:0] head_q, head_d, issue_q, issue_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          outst_q, outst_d, drop_q, drop_d;

    logic          alloc, issue_fire, resp_take, resp_fill, free_head;
    logic [PW-1:0] resp_idx;

    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] w,
                                               input logic [1:0] a,
                                               input logic [1:0] sz,
                                               input logic u);
        logic [XLEN-1:0] sh;
        logic [7:0]      b;
        logic [15:0]     h;
        extend = w;
        sh = '0;
        b  = '0;
        h  = '0;
        case (sz)
            2'd0: begin
                sh = w >> {a, 3'b000};
                b  = sh[7:0];
                extend = {{(XLEN-8){~u & b[7]}}, b};
            end
            2'd1: begin
                sh = w >> {a[1], 4'b0000};
                h  = sh[15:0];
                extend = {{(XLEN-16){~u & h[15]}}, h};
            end
            default: extend = w;
        endcase
    endfunction

    assign full      = (count_q == CW'(LQ_DEPTH));
    assign count     = count_q;
    assign mem_req   = (st_q[issue_q] == E_WAIT) && !pending_stores && !outst_q && !drop_q;
    assign mem_addr  = mem_req ? {addr_q[issue_q][XLEN-1:2], 2'b00} : '0;
    assign cdb_valid = (st_q[head_q] == E_DONE);
    assign cdb_rob_tag = cdb_valid ? tag_q[head_q]  : '0;
    assign cdb_value   = cdb_valid ? data_q[head_q] : '0;

    assign alloc      = lq_in_valid && !full && !flush;
    assign issue_fire = mem_req && !mem_busy && !flush;
    assign resp_take  = mem_resp_valid && outst_q;
    assign resp_fill  = resp_take && !drop_q && !flush;
    assign free_head  = cdb_valid && cdb_grant && !flush;
    // Only one request is ever in flight, so it is the entry just behind issue.
    assign resp_idx   = issue_q - PW'(1);

    always_comb begin
        head_d  = head_q;
        issue_d = issue_q;
        tail_d  = tail_q;
        count_d = count_q;
        outst_d = outst_q;
        drop_d  = drop_q;
        if (flush) begin
            head_d  = '0;
            issue_d = '0;
            tail_d  = '0;
            count_d = '0;
            // A response landing in the flush cycle retires the in-flight read.
            outst_d = outst_q && !mem_resp_valid;
            drop_d  = outst_q && !mem_resp_valid;
        end else begin
            if (alloc)      tail_d  = tail_q + PW'(1);
            if (issue_fire) begin
                issue_d = issue_q + PW'(1);
                outst_d = 1'b1;
            end
            if (resp_take) begin
                outst_d = 1'b0;
                drop_d  = 1'b0;
            end
            if (free_head)  head_d  = head_q + PW'(1);
            count_d = count_q + CW'(alloc) - CW'(free_head);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            issue_q <= '0;
            tail_q  <= '0;
            count_q <= '0;
            outst_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            issue_q <= issue_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LQ_DEPTH; i++) begin
                st_q[i]   <= E_FREE;
                addr_q[i] <= '0;
                data_q[i] <= '0;
                tag_q[i]  <= '0;
                size_q[i] <= '0;
                uns_q[i]  <= 1'b0;
            end
        end else if (flush) begin
            for (int i = 0; i < LQ_DEPTH; i++) st_q[i] <= E_FREE;
        end else begin
            if (alloc) begin
                st_q[tail_q]   <= E_WAIT;
                addr_q[tail_q] <= lq_in_address;
                tag_q[tail_q]  <= lq_in_rob_tag;
                size_q[tail_q] <= lq_in_size;
                uns_q[tail_q]  <= lq_in_unsigned;
            end
            if (issue_fire) st_q[issue_q] <= E_ISSUED;
            if (resp_fill) begin
                st_q[resp_idx]   <= E_DONE;
                data_q[resp_idx] <= extend(mem_resp_data, addr_q[resp_idx][1:0],
                                           size_q[resp_idx], uns_q[resp_idx]);
            end
            if (free_head) st_q[head_q] <= E_FREE;
        end
    end
endmodule

// File: tb/tb_load_queue.sv
// Randomized and directed bench for load_queue against a queue-based model.
module tb_load_queue;
    logic        clock = 1'b0;
    logic        reset;
    logic        lq_in_valid, lq_in_unsigned, pending_stores, mem_busy;
    logic [31:0] lq_in_address, mem_resp_data;
    logic [4:0]  lq_in_rob_tag;
    logic [1:0]  lq_in_size;
    logic        mem_resp_valid, cdb_grant, flush;
    logic        full, mem_req, cdb_valid;
    logic [2:0]  count;
    logic [31:0] mem_addr, cdb_value;
    logic [4:0]  cdb_rob_tag;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    load_queue #(.LQ_DEPTH(4), .XLEN(32), .ROB_TAG_LEN(5)) dut (
        .clock(clock), .reset(reset),
        .lq_in_valid(lq_in_valid), .lq_in_address(lq_in_address),
        .lq_in_rob_tag(lq_in_rob_tag), .lq_in_size(lq_in_size),
        .lq_in_unsigned(lq_in_unsigned), .full(full), .count(count),
        .pending_stores(pending_stores), .mem_busy(mem_busy),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .cdb_valid(cdb_valid), .cdb_rob_tag(cdb_rob_tag), .cdb_value(cdb_value),
        .cdb_grant(cdb_grant), .flush(flush)
    );

    typedef struct {
        logic [31:0] addr;
        logic [4:0]  tag;
        logic [1:0]  size;
        logic        uns;
        int          st;    // 0 waiting, 1 in flight, 2 data ready
        logic [31:0] val;
    } ent_t;

    ent_t mq[$];
    bit   m_out, m_drop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_ext(input logic [31:0] d, input logic [31:0] a,
                                          input logic [1:0] sz, input logic u);
        logic [31:0] v;
        int sh;
        if (sz == 2'd0) begin
            sh = int'(a % 4) * 8;
            v = (d >> sh) & 32'hFF;
            if (!u && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            sh = ((a / 2) % 2 == 1) ? 16 : 0;
            v = (d >> sh) & 32'hFFFF;
            if (!u && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    function automatic int first_wait();
        foreach (mq[i]) if (mq[i].st == 0) return i;
        return -1;
    endfunction

    function automatic bit m_req();
        return first_wait() >= 0 && !pending_stores && !m_out && !m_drop;
    endfunction

    function automatic bit m_cv();
        return mq.size() > 0 && mq[0].st == 2;
    endfunction

    task automatic compare();
        int w;
        w = first_wait();
        check("full",  32'(full),  32'(mq.size() == 4));
        check("count", 32'(count), 32'(mq.size()));
        check("mem_req", 32'(mem_req), 32'(m_req()));
        check("mem_addr", mem_addr, m_req() ? (mq[w].addr & 32'hFFFF_FFFC) : 32'h0);
        check("cdb_valid", 32'(cdb_valid), 32'(m_cv()));
        check("cdb_tag", 32'(cdb_rob_tag), m_cv() ? 32'(mq[0].tag) : 32'h0);
        check("cdb_value", cdb_value, m_cv() ? mq[0].val : 32'h0);
    endtask

    task automatic model_step();
        int  w;
        bit  req, cv, was_full;
        ent_t e;
        w = first_wait();
        req = m_req();
        cv = m_cv();
        was_full = (mq.size() == 4);
        if (flush) begin
            if (m_out && !mem_resp_valid) m_drop = 1;
            else if (m_out) begin m_out = 0; m_drop = 0; end
            mq.delete();
        end else begin
            if (mem_resp_valid && m_out) begin
                if (!m_drop) begin
                    foreach (mq[i]) if (mq[i].st == 1) begin
                        mq[i].val = m_ext(mem_resp_data, mq[i].addr, mq[i].size, mq[i].uns);
                        mq[i].st = 2;
                    end
                end
                m_out = 0;
                m_drop = 0;
            end
            if (req && !mem_busy) begin
                mq[w].st = 1;
                m_out = 1;
            end
            if (cv && cdb_grant) void'(mq.pop_front());
            if (lq_in_valid && !was_full) begin
                e.addr = lq_in_address; e.tag = lq_in_rob_tag; e.size = lq_in_size;
                e.uns = lq_in_unsigned; e.st = 0; e.val = 0;
                mq.push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(negedge clock);
        compare();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic idle();
        lq_in_valid = 0; lq_in_address = 0; lq_in_rob_tag = 0; lq_in_size = 0;
        lq_in_unsigned = 0; pending_stores = 0; mem_busy = 0; mem_resp_valid = 0;
        mem_resp_data = 0; cdb_grant = 0; flush = 0;
    endtask

    task automatic rnd_inputs();
        lq_in_valid    = 1'($urandom % 2);
        lq_in_address  = $urandom;
        lq_in_rob_tag  = 5'($urandom);
        lq_in_size     = 2'($urandom % 3);
        lq_in_unsigned = 1'($urandom % 2);
        pending_stores = ($urandom % 4 == 0);
        mem_busy       = ($urandom % 4 == 0);
        mem_resp_valid = ($urandom % 3 == 0);
        mem_resp_data  = $urandom;
        cdb_grant      = 1'($urandom % 2);
        flush          = ($urandom % 40 == 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_full"}, 32'(full), 0);
        check({tag, "_count"}, 32'(count), 0);
        check({tag, "_req"}, 32'(mem_req), 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_cv"}, 32'(cdb_valid), 0);
        check({tag, "_tag"}, 32'(cdb_rob_tag), 0);
        check({tag, "_val"}, cdb_value, 0);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic u,
                           input logic [4:0] tg, input logic [31:0] d, input int busy,
                           input int stall, input logic [31:0] exp);
        idle();
        lq_in_valid = 1; lq_in_address = a; lq_in_size = sz; lq_in_unsigned = u;
        lq_in_rob_tag = tg;
        tick();
        idle();
        mem_busy = 1;
        repeat (busy) begin
            tick();
            check("req_held", 32'(mem_req), 1);
        end
        mem_busy = 0;
        tick();
        mem_resp_valid = 1; mem_resp_data = d;
        tick();
        mem_resp_valid = 0;
        check("ld_cv", 32'(cdb_valid), 1);
        check("ld_tag", 32'(cdb_rob_tag), 32'(tg));
        check("ld_val", cdb_value, exp);
        repeat (stall) begin
            tick();
            check("stall_val", cdb_value, exp);
            check("stall_cnt", 32'(count), 1);
        end
        cdb_grant = 1;
        tick();
        cdb_grant = 0;
        check("ld_freed", 32'(count), 0);
    endtask

    initial begin
        m_out = 0; m_drop = 0;
        reset = 0;
        idle();
        repeat (4) begin
            rnd_inputs();
            @(negedge clock);
            check_zero("rst");
        end
        @(posedge clock); #1;
        idle();
        reset = 1;
        tick();
        check_zero("post_rst");

        // fill with stores pending: fifth load is refused
        pending_stores = 1;
        for (int i = 0; i < 5; i++) begin
            lq_in_valid = 1; lq_in_address = 32'h100 + 32'(i * 4); lq_in_rob_tag = 5'(i + 1);
            tick();
        end
        lq_in_valid = 0;
        check("fill_full", 32'(full), 1);
        check("fill_count", 32'(count), 4);
        cdb_grant = 1;
        tick();
        cdb_grant = 0;
        check("grant_nop", 32'(count), 4);
        tick();
        pending_stores = 0;
        #1;
        check("order_req", 32'(mem_req), 1);
        check("order_addr", mem_addr, 32'h100);
        flush = 1;
        tick();
        flush = 0;
        check("flush_cnt", 32'(count), 0);

        do_load(32'h103, 2'd0, 1'b0, 5'd3, 32'h8011_2233, 2, 0, 32'hFFFF_FF80);
        do_load(32'h103, 2'd0, 1'b1, 5'd4, 32'h8011_2233, 0, 4, 32'h0000_0080);
        do_load(32'h102, 2'd1, 1'b0, 5'd5, 32'h8011_2233, 1, 0, 32'hFFFF_8011);

        // flush with a read in flight; its late response must be dropped
        idle();
        lq_in_valid = 1; lq_in_address = 32'h300; lq_in_rob_tag = 5'd9;
        tick();
        idle();
        tick();
        flush = 1;
        tick();
        flush = 0;
        check("fl_count", 32'(count), 0);
        mem_resp_valid = 1; mem_resp_data = 32'hDEAD_BEEF;
        tick();
        mem_resp_valid = 0;
        check("fl_drop_cv", 32'(cdb_valid), 0);
        do_load(32'h200, 2'd2, 1'b0, 5'd7, 32'h1234_5678, 0, 0, 32'h1234_5678);

        for (int c = 0; c < 2000; c++) begin
            rnd_inputs();
            tick();
        end

        // asynchronous reset in the middle of traffic
        rnd_inputs();
        flush = 0;
        reset = 0;
        #1;
        mq.delete(); m_out = 0; m_drop = 0;
        check_zero("mid_rst");
        @(posedge clock); #1;
        idle();
        reset = 1;
        mem_resp_valid = 1; mem_resp_data = 32'h5555_AAAA;
        tick();
        check("post_rst_cv", 32'(cdb_valid), 0);

        for (int c = 0; c < 1500; c++) begin
            rnd_inputs();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
